// File: rtl/clk_en_sched_pkg.sv
// clk_en_sched shared types.
// FSM state encoding and cycle-counter width.
package clk_en_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } sched_state_t;

  localparam int RUN_W = 8;

endpackage

// File: rtl/clk_en_div.sv
// Divide-by-div_l tick generator.
// Emits tick on the last cycle of each divide period.
module clk_en_div
  import clk_en_sched_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div_l,
  output logic             tick
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_wrap;

  assign w_wrap = (r_div_cnt == div_l - DIV_W'(1));
  assign tick   = run && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (clr) begin
      r_div_cnt <= '0;
    end else if (run) begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: emulated sub-clock with rise/fall strobes,
// event counter and sticky all-ones detector, bounded run length.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int DIV_W   = 4,
  parameter int CNT_W   = 2,
  parameter int RUN_LEN = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             sub_phase,
  output logic             rise_en,
  output logic             fall_en,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             all_ones,
  output logic             done
);

  sched_state_t     r_state;
  logic [DIV_W-1:0] r_div_l;
  logic [RUN_W-1:0] r_cyc_cnt;
  logic             r_busy;
  logic             r_phase;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_evt;
  logic             r_all;
  logic             r_done;

  logic w_start;
  logic w_run;
  logic w_tick;
  logic w_last;

  assign w_start = (r_state == IDLE) && start;
  assign w_run   = (r_state == RUN);
  assign w_last  = (r_cyc_cnt == RUN_W'(RUN_LEN - 1));

  clk_en_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_start),
    .run  (w_run),
    .div_l(r_div_l),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div_l   <= '0;
      r_cyc_cnt <= '0;
      r_busy    <= 1'b0;
      r_phase   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_evt     <= '0;
      r_all     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_div_l   <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            r_cyc_cnt <= '0;
            r_phase   <= 1'b0;
            r_evt     <= '0;
            r_all     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_cyc_cnt <= r_cyc_cnt + RUN_W'(1);
          // detector reads the pre-edge count
          if (w_tick) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_rise <= 1'b1;
              if (&r_evt) r_all <= 1'b1;
            end else begin
              r_fall <= 1'b1;
              r_evt  <= r_evt + CNT_W'(1);
            end
          end
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign sub_phase = r_phase;
  assign rise_en   = r_rise;
  assign fall_en   = r_fall;
  assign evt_cnt   = r_evt;
  assign all_ones  = r_all;
  assign done      = r_done;

endmodule

// File: tb/tb_clk_en_sched.sv
// Randomized bench for clk_en_sched against a tick-count model.
// Outputs are derived from elapsed RUN cycles and tick totals.
module tb_clk_en_sched;

  localparam int DIV_W   = 4;
  localparam int CNT_W   = 2;
  localparam int RUN_LEN = 10;
  localparam int MODC    = 1 << CNT_W;
  localparam int ALL_N   = 2 * (MODC - 1) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy;
  logic             sub_phase;
  logic             rise_en;
  logic             fall_en;
  logic [CNT_W-1:0] evt_cnt;
  logic             all_ones;
  logic             done;

  clk_en_sched #(
    .DIV_W  (DIV_W),
    .CNT_W  (CNT_W),
    .RUN_LEN(RUN_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .sub_phase(sub_phase),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .evt_cnt  (evt_cnt),
    .all_ones (all_ones),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 run, 2 finish; n = ticks since start
  int m_ph = 0;
  int m_k  = 0;
  int m_d  = 1;
  int m_n  = 0;
  bit m_tk = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0;
      m_k  = 0;
      m_n  = 0;
      m_tk = 1'b0;
    end else begin
      m_tk = 1'b0;
      case (m_ph)
        0: if (start) begin
          m_d  = (cfg_div == 0) ? 1 : int'(cfg_div);
          m_k  = 0;
          m_n  = 0;
          m_ph = 1;
        end
        1: begin
          m_k++;
          if (m_k % m_d == 0) begin
            m_tk = 1'b1;
            m_n++;
          end
          if (stop) m_ph = 0;
          else if (m_k == RUN_LEN) m_ph = 2;
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_ph != 0);
      check("done", done, m_ph == 2);
      check("sub_phase", sub_phase, m_n % 2);
      check("evt_cnt", evt_cnt, (m_n / 2) % MODC);
      check("all_ones", all_ones, m_n >= ALL_N);
      check("rise_en", rise_en, m_tk && (m_n % 2 == 1));
      check("fall_en", fall_en, m_tk && (m_n % 2 == 0));
    end
  end

  task automatic do_run(input logic [DIV_W-1:0] cfg, input int stop_k,
                        input bit with_stop, input bit noise,
                        output int dn);
    int k;
    dn = 0;
    @(negedge clk);
    start   = 1'b1;
    stop    = with_stop;
    cfg_div = cfg;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    k = 1;
    while (m_ph != 0 && k < 40) begin
      if (done) dn++;
      if (k == stop_k) stop = 1'b1;
      if (noise) begin
        start   = 1'($urandom);
        cfg_div = DIV_W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      k++;
    end
    if (k >= 40) check("run_timeout", 1, 0);
  endtask

  task automatic final_vals(input string nm, input int e_evt,
                            input int e_all, input int e_ph);
    check({nm, "_evt"}, evt_cnt, e_evt);
    check({nm, "_all"}, all_ones, e_all);
    check({nm, "_phase"}, sub_phase, e_ph);
  endtask

  initial begin
    int dn;
    #1 rst = 1'b1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_evt", evt_cnt, 0);
    check("rst_strobes", {rise_en, fall_en, sub_phase, all_ones, done}, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    do_run(4'd1, 0, 1'b0, 1'b0, dn);
    check("div1_done", dn, 1);
    final_vals("div1", 1, 1, 0);

    do_run(4'd3, 0, 1'b0, 1'b0, dn);
    check("div3_done", dn, 1);
    final_vals("div3", 1, 0, 1);

    do_run(4'd0, 0, 1'b0, 1'b0, dn);
    check("div0_done", dn, 1);
    final_vals("div0", 1, 1, 0);

    do_run(4'd1, 5, 1'b0, 1'b0, dn);
    check("abort_done", dn, 0);
    check("abort_busy", busy, 0);
    final_vals("abort", 2, 0, 1);
    repeat (3) @(negedge clk);
    final_vals("abort_hold", 2, 0, 1);

    do_run(4'd15, 0, 1'b0, 1'b0, dn);
    check("clr_done", dn, 1);
    final_vals("clr", 0, 0, 0);

    do_run(4'd2, 0, 1'b0, 1'b1, dn);
    check("noise_done", dn, 1);
    final_vals("noise", 2, 0, 1);

    do_run(4'd1, 0, 1'b1, 1'b0, dn);
    check("startstop_done", dn, 1);
    final_vals("startstop", 1, 1, 0);

    @(negedge clk);
    start   = 1'b1;
    cfg_div = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_evt", evt_cnt, 0);
    check("mrst_bits", {rise_en, fall_en, sub_phase, all_ones}, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    do_run(4'd1, 0, 1'b0, 1'b0, dn);
    check("post_rst_done", dn, 1);
    final_vals("post_rst", 1, 1, 0);

    repeat (30) begin
      logic [DIV_W-1:0] c;
      int sk;
      c  = ($urandom % 4 == 0) ? DIV_W'($urandom) : DIV_W'($urandom % 4);
      sk = ($urandom % 3 == 0) ? int'($urandom_range(1, 12)) : 0;
      do_run(c, sk, 1'($urandom), 1'($urandom), dn);
      check("rand_done", dn, (sk >= 1 && sk <= RUN_LEN) ? 0 : 1);
      repeat ($urandom % 3) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
